cmd_engine: RTL and testbench

Parametrised command execution engine; successor to the fixed 8-bit command dispatcher. Pops command words from the command FIFO and executes single and burst reads and writes, plus fill, against a synchronous RAM. Pushes one response word per read beat, or one acknowledge per write or fill, into the response FIFO. Honours response-FIFO backpressure and reports range errors. Sits between cmd_fifo and resp_fifo/uart_tx, replacing the single-beat dispatcher.

---
 rtl/cmd_engine_pkg.sv | 30 +++
 rtl/cmd_engine.sv | 203 ++++++++++++++++++++
 tb/tb_cmd_engine.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_engine_pkg.sv
// rtl/cmd_engine_pkg.sv - opcode, status and state types for cmd_engine
package cmd_engine_pkg;

    typedef enum logic [1:0] {
        OP_READ       = 2'd0,
        OP_WRITE      = 2'd1,
        OP_BURST_READ = 2'd2,
        OP_FILL       = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        RSP_OK   = 2'd0,
        RSP_ERR  = 2'd1,
        RSP_CSUM = 2'd2
    } rsp_status_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXEC,
        ST_RD_WAIT,
        ST_RESP
`ifdef CMD_ENGINE_CHECKSUM_EN
        , ST_CSUM
`endif
    } state_e;

    localparam int ERR_COUNT_W = 8;

endpackage

// File: rtl/cmd_engine.sv
// rtl/cmd_engine.sv - command engine: single/burst read, write and fill against a sync RAM (CMD_ENGINE_CHECKSUM_EN adds burst XOR checksum)
module cmd_engine
    import cmd_engine_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              cmd_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write_en,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read_en,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              rsp_full,
    output logic              rsp_wr_en,
    output logic [1:0]        rsp_status,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic [7:0]        err_count
);

    state_e                 state, state_n;
    cmd_op_e                op_q;
    logic [ADDR_W-1:0]      addr_q, start_q;
    logic [DATA_W-1:0]      data_q;
    logic [LEN_W-1:0]       len_q, cnt_q;
    rsp_status_e            status_q;
    logic [ADDR_W-1:0]      rsp_addr_q;
    logic [DATA_W-1:0]      rsp_data_q;
    logic [ERR_COUNT_W-1:0] err_q;
    logic [ADDR_W:0]        end_addr;
    logic                   range_err;
    logic                   multi_beat;
    logic                   more_beats;
`ifdef CMD_ENGINE_CHECKSUM_EN
    logic [DATA_W-1:0]      csum_q;
`endif

    // Last beat address computed one bit wider so a wrap past the top shows as a carry.
    assign end_addr   = {1'b0, addr_q} + (ADDR_W+1)'(len_q);
    assign multi_beat = (op_q == OP_BURST_READ) || (op_q == OP_FILL);
    assign range_err  = multi_beat && end_addr[ADDR_W];
    assign more_beats = (op_q == OP_BURST_READ) && (cnt_q != '0);

    assign mem_addr       = addr_q;
    assign mem_write_data = data_q;
    assign rsp_status     = status_q;
    assign rsp_addr       = rsp_addr_q;
    assign rsp_data       = rsp_data_q;
    assign busy           = (state != ST_IDLE);
    assign err_count      = err_q;

    always_comb begin
        state_n      = state;
        cmd_rd_en    = 1'b0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        rsp_wr_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid && !rst) begin
                    cmd_rd_en = 1'b1;
                    state_n   = ST_DECODE;
                end
            end
            ST_DECODE: state_n = range_err ? ST_RESP : ST_EXEC;
            ST_EXEC: begin
                case (op_q)
                    OP_READ, OP_BURST_READ: begin
                        mem_read_en = 1'b1;
                        state_n     = ST_RD_WAIT;
                    end
                    OP_WRITE: begin
                        mem_write_en = 1'b1;
                        state_n      = ST_RESP;
                    end
                    default: begin
                        mem_write_en = 1'b1;
                        if (cnt_q == '0) state_n = ST_RESP;
                    end
                endcase
            end
            ST_RD_WAIT: state_n = ST_RESP;
            ST_RESP: begin
                if (!rsp_full) begin
                    rsp_wr_en = 1'b1;
                    if (more_beats) state_n = ST_EXEC;
`ifdef CMD_ENGINE_CHECKSUM_EN
                    else if (op_q == OP_BURST_READ && status_q == RSP_OK) state_n = ST_CSUM;
`endif
                    else state_n = ST_IDLE;
                end
            end
`ifdef CMD_ENGINE_CHECKSUM_EN
            ST_CSUM: begin
                if (!rsp_full) begin
                    rsp_wr_en = 1'b1;
                    state_n   = ST_IDLE;
                end
            end
`endif
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            op_q       <= OP_READ;
            addr_q     <= '0;
            start_q    <= '0;
            data_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            status_q   <= RSP_OK;
            rsp_addr_q <= '0;
            rsp_data_q <= '0;
            err_q      <= '0;
`ifdef CMD_ENGINE_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state <= state_n;
            case (state)
                ST_IDLE: begin
                    if (cmd_rd_en) begin
                        op_q    <= cmd_op_e'(cmd_op);
                        addr_q  <= cmd_addr;
                        start_q <= cmd_addr;
                        data_q  <= cmd_data;
                        len_q   <= cmd_len;
                    end
                end
                ST_DECODE: begin
`ifdef CMD_ENGINE_CHECKSUM_EN
                    csum_q <= '0;
`endif
                    // A rejected command leaves the counter at zero so RESP never loops back.
                    if (range_err) begin
                        cnt_q      <= '0;
                        status_q   <= RSP_ERR;
                        rsp_addr_q <= start_q;
                        rsp_data_q <= '0;
                    end else begin
                        cnt_q <= multi_beat ? len_q : '0;
                    end
                end
                ST_EXEC: begin
                    if (op_q == OP_WRITE) begin
                        status_q   <= RSP_OK;
                        rsp_addr_q <= addr_q;
                        rsp_data_q <= data_q;
                    end else if (op_q == OP_FILL) begin
                        if (cnt_q == '0) begin
                            status_q   <= RSP_OK;
                            rsp_addr_q <= start_q;
                            rsp_data_q <= data_q;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                            cnt_q  <= cnt_q - 1'b1;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    status_q   <= RSP_OK;
                    rsp_addr_q <= addr_q;
                    rsp_data_q <= mem_read_data;
`ifdef CMD_ENGINE_CHECKSUM_EN
                    csum_q     <= csum_q ^ mem_read_data;
`endif
                end
                ST_RESP: begin
                    if (rsp_wr_en) begin
                        if (status_q == RSP_ERR && err_q != {ERR_COUNT_W{1'b1}})
                            err_q <= err_q + 1'b1;
                        if (more_beats) begin
                            addr_q <= addr_q + 1'b1;
                            cnt_q  <= cnt_q - 1'b1;
                        end
`ifdef CMD_ENGINE_CHECKSUM_EN
                        if (state_n == ST_CSUM) begin
                            status_q   <= RSP_CSUM;
                            rsp_addr_q <= start_q;
                            rsp_data_q <= csum_q;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_engine.sv
// tb/tb_cmd_engine.sv - randomized self-checking bench for cmd_engine against a behavioural model
module tb_cmd_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [7:0] cmd_addr, cmd_data;
    logic [3:0] cmd_len;
    logic       cmd_rd_en;
    logic [7:0] mem_addr;
    logic       mem_write_en;
    logic [7:0] mem_write_data;
    logic       mem_read_en;
    logic [7:0] mem_read_data;
    logic       rsp_full;
    logic       rsp_wr_en;
    logic [1:0] rsp_status;
    logic [7:0] rsp_addr, rsp_data;
    logic       busy;
    logic [7:0] err_count;

    cmd_engine dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .cmd_len(cmd_len), .cmd_rd_en(cmd_rd_en), .mem_addr(mem_addr),
        .mem_write_en(mem_write_en), .mem_write_data(mem_write_data), .mem_read_en(mem_read_en),
        .mem_read_data(mem_read_data), .rsp_full(rsp_full), .rsp_wr_en(rsp_wr_en),
        .rsp_status(rsp_status), .rsp_addr(rsp_addr), .rsp_data(rsp_data), .busy(busy),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [1:0] op; logic [7:0] addr; logic [7:0] data; logic [3:0] len; } cmd_t;
    typedef struct { logic [1:0] st; logic [7:0] a; logic [7:0] d; } rsp_t;

    cmd_t       cq[$];
    rsp_t       eq[$];
    int         pops[$];
    logic [7:0] ram  [256];
    logic [7:0] mram [256];
    int tests = 0, fails = 0;
    int cyc = 0, pop_cyc = 0, first_lat = 0, last_rsp_cyc = 0, rsp_seen = 0;
    int wr_cnt = 0, rd_cnt = 0, wr_first = -1, wr_last = 0;
    int errs_model = 0, full_pct = 0, full_hold = 0;
    bit lat_pending = 0;
    logic [1:0] last_st;
    logic [7:0] last_d;

    // RAM behind the engine; reset reloads it from the model so abandoned fills stay consistent.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) ram[i] <= mram[i];
        end else begin
            if (mem_write_en) ram[mem_addr] <= mem_write_data;
            if (mem_read_en) mem_read_data <= ram[mem_addr];
        end
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void push_rsp(logic [1:0] st, logic [7:0] a, logic [7:0] d);
        rsp_t r;
        r.st = st; r.a = a; r.d = d;
        eq.push_back(r);
    endfunction

    // Expected responses of one command, from the command semantics alone.
    function automatic void model_cmd(cmd_t c);
        int         last = int'(c.addr) + int'(c.len);
        logic [7:0] x = 8'h00;
        logic [7:0] a;
        case (c.op)
            2'd0: push_rsp(2'd0, c.addr, mram[c.addr]);
            2'd1: begin
                mram[c.addr] = c.data;
                push_rsp(2'd0, c.addr, c.data);
            end
            default: begin
                if (last > 255) begin
                    push_rsp(2'd1, c.addr, 8'h00);
                    if (errs_model < 255) errs_model++;
                end else if (c.op == 2'd2) begin
                    for (int i = 0; i <= int'(c.len); i++) begin
                        a = 8'(int'(c.addr) + i);
                        x ^= mram[a];
                        push_rsp(2'd0, a, mram[a]);
                    end
`ifdef CMD_ENGINE_CHECKSUM_EN
                    push_rsp(2'd2, c.addr, x);
`endif
                end else begin
                    for (int i = 0; i <= int'(c.len); i++) mram[8'(int'(c.addr) + i)] = c.data;
                    push_rsp(2'd0, c.addr, c.data);
                end
            end
        endcase
    endfunction

    task automatic drive_head();
        cmd_valid = (cq.size() != 0);
        if (cq.size() != 0) begin
            cmd_op = cq[0].op; cmd_addr = cq[0].addr; cmd_data = cq[0].data; cmd_len = cq[0].len;
        end else begin
            cmd_op = 2'd0; cmd_addr = 8'h00; cmd_data = 8'h00; cmd_len = 4'h0;
        end
    endtask

    task automatic send(logic [1:0] op, logic [7:0] addr, logic [7:0] data, logic [3:0] len);
        cmd_t c;
        c.op = op; c.addr = addr; c.data = data; c.len = len;
        cq.push_back(c);
        drive_head();
    endtask

    task automatic cycle();
        bit   do_pop;
        rsp_t e;
        @(negedge clk);
        cyc++;
        do_pop = cmd_rd_en;
        check("strobe_excl", {31'd0, mem_read_en & mem_write_en}, 0);
        if (cmd_rd_en) check("rd_en_not_busy", {31'd0, busy}, 0);
        if (mem_write_en) begin
            wr_cnt++; wr_last = cyc;
            if (wr_first < 0) wr_first = cyc;
        end
        if (mem_read_en) rd_cnt++;
        if (rsp_wr_en) begin
            rsp_seen++; last_rsp_cyc = cyc; last_st = rsp_status; last_d = rsp_data;
            if (lat_pending) begin first_lat = cyc - pop_cyc; lat_pending = 0; end
            check("rsp_expected", {31'd0, eq.size() != 0}, 1);
            if (eq.size() != 0) begin
                e = eq.pop_front();
                check("rsp_status", {30'd0, rsp_status}, {30'd0, e.st});
                check("rsp_addr", {24'd0, rsp_addr}, {24'd0, e.a});
                check("rsp_data", {24'd0, rsp_data}, {24'd0, e.d});
            end
        end
        if (do_pop) begin
            model_cmd(cq[0]);
            pop_cyc = cyc; lat_pending = 1; wr_first = -1;
            pops.push_back(cyc);
        end
        @(posedge clk);
        #1;
        if (do_pop) void'(cq.pop_front());
        drive_head();
        if (full_hold > 0) begin
            rsp_full = 1'b1;
            full_hold--;
        end else begin
            rsp_full = ($urandom_range(0, 99) < full_pct);
        end
    endtask

    task automatic run_until_idle(int budget);
        int n = 0;
        do begin
            cycle();
            n++;
        end while ((cq.size() != 0 || busy) && n < budget);
        check("drain_in_budget", {31'd0, n < budget}, 1);
    endtask

    int wr0, rd0, rs0;

    initial begin
        rst = 1'b1; rsp_full = 1'b0;
        for (int i = 0; i < 256; i++) mram[i] = 8'($urandom);
        drive_head();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_cmd_rd_en", {31'd0, cmd_rd_en}, 0);
        check("rst_rsp_wr_en", {31'd0, rsp_wr_en}, 0);
        check("rst_strobes", {30'd0, mem_read_en, mem_write_en}, 0);
        check("rst_rsp_regs", {8'd0, rsp_addr, rsp_data, 6'd0, rsp_status}, 0);
        check("rst_err_count", {24'd0, err_count}, 0);
        rst = 1'b0;

        send(2'd1, 8'h10, 8'hA5, 4'd0);
        run_until_idle(100);
        check("write_lat", first_lat, 3);
        send(2'd0, 8'h10, 8'h00, 4'd0);
        run_until_idle(100);
        check("read_lat", first_lat, 4);
        check("read_val", {24'd0, last_d}, 32'hA5);
        send(2'd0, 8'h10, 8'h00, 4'd0);
        send(2'd0, 8'h11, 8'h00, 4'd0);
        run_until_idle(100);
        check("read_b2b_gap", pops[pops.size()-1] - pops[pops.size()-2], 5);

        wr0 = wr_cnt;
        send(2'd3, 8'h20, 8'h3C, 4'd3);
        run_until_idle(100);
        check("fill_writes", wr_cnt - wr0, 4);
        check("fill_first_wr", wr_first - pop_cyc, 2);
        check("fill_last_wr", wr_last - pop_cyc, 5);
        check("fill_ack_lat", first_lat, 6);
        rs0 = rsp_seen;
        send(2'd2, 8'h20, 8'h00, 4'd3);
        run_until_idle(100);
        check("burst_lat", first_lat, 4);
`ifdef CMD_ENGINE_CHECKSUM_EN
        check("burst_rsps", rsp_seen - rs0, 5);
        check("burst_last_cyc", last_rsp_cyc - pop_cyc, 14);
`else
        check("burst_rsps", rsp_seen - rs0, 4);
        check("burst_last_cyc", last_rsp_cyc - pop_cyc, 13);
`endif

        wr0 = wr_cnt; rd0 = rd_cnt;
        send(2'd2, 8'hFE, 8'h00, 4'd3);
        run_until_idle(100);
        check("err_no_mem", (wr_cnt - wr0) + (rd_cnt - rd0), 0);
        check("err_count_1", {24'd0, err_count}, 1);
        check("err_lat", first_lat, 2);

        send(2'd2, 8'h20, 8'h00, 4'd1);
        while (!lat_pending) cycle();
        cycle(); cycle();
        full_hold = 5;
        cycle();
        for (int k = 0; k < 5; k++) begin
            #1;
            check("hold_no_push", {31'd0, rsp_wr_en}, 0);
            check("hold_payload", {22'd0, rsp_status, rsp_addr, rsp_data}, {22'd0, eq[0].st, eq[0].a, eq[0].d});
            cycle();
        end
        run_until_idle(100);
        check("hold_lat", first_lat, 9);

        send(2'd1, 8'h30, 8'h01, 4'd0);
        send(2'd1, 8'h31, 8'h02, 4'd0);
        send(2'd1, 8'h32, 8'h04, 4'd0);
        run_until_idle(100);
        rs0 = rsp_seen;
        send(2'd2, 8'h30, 8'h00, 4'd2);
        run_until_idle(100);
`ifdef CMD_ENGINE_CHECKSUM_EN
        check("csum_rsps", rsp_seen - rs0, 4);
        check("csum_last", {22'd0, last_st, last_d}, {22'd0, 2'd2, 8'h07});
`else
        check("csum_rsps", rsp_seen - rs0, 3);
        check("csum_last", {22'd0, last_st, last_d}, {22'd0, 2'd0, 8'h04});
`endif

        rs0 = rsp_seen;
        send(2'd2, 8'h50, 8'h00, 4'd3);
        send(2'd1, 8'h60, 8'h11, 4'd0);
        send(2'd0, 8'h60, 8'h00, 4'd0);
        for (int k = 0; k < 50 && rsp_seen == rs0; k++) cycle();
        check("rst_test_first_beat", rsp_seen - rs0, 1);
        rst = 1'b1;
        cycle();
        eq.delete();
        errs_model = 0;
        lat_pending = 0;
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_outs", {28'd0, rsp_wr_en, mem_read_en, mem_write_en, cmd_rd_en}, 0);
        check("midrst_rsp_regs", {8'd0, rsp_addr, rsp_data, 6'd0, rsp_status}, 0);
        check("midrst_mem_addr", {24'd0, mem_addr}, 0);
        check("midrst_err_count", {24'd0, err_count}, 0);
        rst = 1'b0;
        rs0 = rsp_seen;
        run_until_idle(100);
        check("midrst_after_rsps", rsp_seen - rs0, 2);
        check("midrst_read_back", {24'd0, last_d}, 32'h11);

        full_pct = 30;
        for (int k = 0; k < 150; k++) begin
            send(2'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom),
                 8'($urandom), 4'($urandom));
        end
        run_until_idle(40000);
        full_pct = 0;
        repeat (3) cycle();
        check("final_queue_empty", eq.size(), 0);
        check("final_err_count", {24'd0, err_count}, errs_model);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
